// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one byte UART transmitter among N_REQ requesters.
// Define UART_ARB_RR_EN for round-robin selection; fixed priority (index 0 highest) otherwise.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 12500
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 timeout_err,
    output logic                 arb_idle
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0] ACK_LAST = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCK,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   g_idx;
    logic               last_q;
    logic [CNT_W-1:0]   to_cnt;
    logic [1:0]         ack_cnt;
    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               any_req;
    logic               accept;
    logic [7:0]         cur_byte;

`ifdef UART_ARB_RR_EN
    // Pointer to the requester after the last completed packet owner
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr <= '0;
        end else if (state == S_WAIT_DONE && !tx_busy && last_q) begin
            rr_ptr <= (32'(g_idx) == N_REQ - 1) ? '0 : g_idx + IDX_W'(1);
        end
    end

    assign start_idx = rr_ptr;
`else
    assign start_idx = '0;
`endif

    // First requesting index found scanning upward from start_idx, wrapping
    always_comb begin
        win_idx = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = IDX_W'((32'(start_idx) + 32'(i)) % N_REQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign req_ready = grant & {N_REQ{(state == S_LOCK) && !tx_busy}};
    assign accept    = (state == S_LOCK) && !tx_busy && req_valid[g_idx];
    assign cur_byte  = req_data[{g_idx, 3'b000} +: 8];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IDLE;
            g_idx       <= '0;
            last_q      <= 1'b0;
            to_cnt      <= '0;
            ack_cnt     <= '0;
            grant       <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            arb_idle    <= 1'b1;
        end else begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (any_req) begin
                        state    <= S_LOCK;
                        g_idx    <= win_idx;
                        grant    <= N_REQ'(1'b1) << win_idx;
                        arb_idle <= 1'b0;
                    end
                end
                // Acceptance beats abort, abort beats timeout
                S_LOCK: begin
                    if (accept) begin
                        tx_data  <= cur_byte;
                        last_q   <= req_last[g_idx];
                        tx_start <= 1'b1;
                        to_cnt   <= '0;
                        ack_cnt  <= '0;
                        state    <= S_WAIT_ACK;
                    end else if (!req[g_idx]) begin
                        state    <= S_IDLE;
                        grant    <= '0;
                        arb_idle <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                        grant       <= '0;
                        arb_idle    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                // Leave after busy is seen, or after four quiet cycles
                S_WAIT_ACK: begin
                    if (tx_busy || ack_cnt == ACK_LAST) begin
                        state <= S_WAIT_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 2'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            state    <= S_IDLE;
                            grant    <= '0;
                            arb_idle <= 1'b1;
                        end else begin
                            state <= S_LOCK;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    grant    <= '0;
                    arb_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model and a tx_start scoreboard.
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ       = 4;
    localparam int unsigned TIMEOUT_CYC = 12500;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
    } sb_t;

    logic                 clk;
    logic                 nrst;
    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     grant;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 timeout_err;
    logic                 arb_idle;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int n_start  = 0;
    int last_start = 0;
    int prev_start = 0;
    int busy_len = 3;
    int bcnt     = 0;
    bit ack_en   = 1'b1;
    bit prev_busy = 1'b0;
    bit err_seen = 1'b0;
    int src_idx  = 0;
    logic [N_REQ-1:0] auto_mask;
    logic [8:0] src_q[$];
    sb_t sb[$];
    int mptr = 0;

    uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .nrst(nrst), .req(req), .req_valid(req_valid),
        .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .timeout_err(timeout_err), .arb_idle(arb_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy for busy_len cycles starting the cycle after tx_start
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (tx_start && ack_en) begin
            tx_busy <= 1'b1;
            bcnt    <= busy_len;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            bcnt    <= 0;
            tx_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
        if (timeout_err) err_seen = 1'b1;
    end

    // Scoreboard check on every start pulse
    always @(negedge clk) begin
        if (nrst && tx_start) begin
            sb_t e;
            n_start++;
            prev_start = last_start;
            last_start = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_tx_start", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_tx_data", 32'(tx_data), 32'(e.data));
                chk("sb_grant", 32'(grant), 32'(4'b0001 << e.idx));
            end
        end
    end

    // Requester byte sources
    initial begin
        logic [N_REQ-1:0]   acc;
        logic [N_REQ-1:0]   nv;
        logic [8*N_REQ-1:0] nd;
        logic [N_REQ-1:0]   nl;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (acc[src_idx] && src_q.size() > 0) void'(src_q.pop_front());
            nv = '0;
            nd = '0;
            nl = '0;
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (auto_mask[i]) begin
                    nv[i] = 1'b1;
                    nd[8*i +: 8] = 8'(160 + i);
                    nl[i] = 1'b1;
                end
            end
            if (src_q.size() > 0) begin
                nv[src_idx] = 1'b1;
                nd[8*src_idx +: 8] = src_q[0][7:0];
                nl[src_idx] = src_q[0][8];
            end
            req_valid = nv;
            req_data  = nd;
            req_last  = nl;
        end
    end

    task automatic push_byte(input int idx, input logic [7:0] d, input bit last, input bit expect_out);
        sb_t e;
        src_q.push_back({last, d});
        if (expect_out) begin
            e.idx  = 3'(idx);
            e.data = d;
            sb.push_back(e);
        end
    endtask

    task automatic wait_sb_empty(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!(arb_idle && !tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(arb_idle), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_arb_idle"}, 32'(arb_idle), 32'd1);
    endtask

    function automatic int pick(input logic [N_REQ-1:0] r, input int ptr);
        for (int i = 0; i < int'(N_REQ); i++) begin
            int k;
            k = (ptr + i) % int'(N_REQ);
            if (r[k]) return k;
        end
        return 0;
    endfunction

    initial begin
        int n;
        int g_cyc;
        int s0;
        bit bad;
        logic [N_REQ-1:0] prev_grant;
        sb_t e;

        clk = 1'b0;
        nrst = 1'b0;
        req = '0;
        auto_mask = '0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        nrst = 1'b1;
        @(negedge clk);

        // Single four-byte packet from requester 1, long frames
        busy_len = TIMEOUT_CYC;
        src_idx  = 1;
        push_byte(1, 8'h53, 1'b0, 1'b1);
        push_byte(1, 8'h6E, 1'b0, 1'b1);
        push_byte(1, 8'h61, 1'b0, 1'b1);
        push_byte(1, 8'h70, 1'b1, 1'b1);
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("pkt_grant_first", 32'(grant), 32'h2);
        chk("pkt_arb_idle_low", 32'(arb_idle), 32'd0);
        chk("pkt_req_ready_first", 32'(req_ready), 32'h2);
        bad = 1'b0;
        n = 0;
        while (!arb_idle && n < 4 * (int'(TIMEOUT_CYC) + 20)) begin
            if (grant !== 4'b0010) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        req = '0;
        chk("pkt_idle_reached", 32'(arb_idle), 32'd1);
        chk("pkt_grant_constant", 32'(bad), 32'd0);
        chk("pkt_idle_latency", 32'(cyc - fall_cyc), 32'd1);
        chk("pkt_all_bytes", 32'(sb.size()), 32'd0);
        wait_idle("pkt_settle", 50);

        // Timeout with no byte offered
        busy_len = 3;
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        g_cyc = cyc;
        chk("to_grant", 32'(grant), 32'h4);
        prev_grant = grant;
        n = 0;
        while (!timeout_err && n < int'(TIMEOUT_CYC) + 20) begin
            prev_grant = grant;
            @(negedge clk);
            n++;
        end
        req = '0;
        chk("to_pulse_seen", 32'(timeout_err), 32'd1);
        chk("to_latency", 32'(cyc - g_cyc), 32'(TIMEOUT_CYC));
        chk("to_grant_before", 32'(prev_grant), 32'h4);
        chk("to_grant_cleared", 32'(grant), 32'd0);
        @(negedge clk);
        chk("to_single_pulse", 32'(timeout_err), 32'd0);
        chk("to_stays_idle", 32'(grant), 32'd0);
        wait_idle("to_settle", 20);

        // Abort after two of four bytes, requester 3 pending
        err_seen = 1'b0;
        src_idx = 0;
        s0 = n_start;
        push_byte(0, 8'h11, 1'b0, 1'b1);
        push_byte(0, 8'h22, 1'b0, 1'b1);
        push_byte(0, 8'h33, 1'b0, 1'b0);
        push_byte(0, 8'h44, 1'b1, 1'b0);
        @(negedge clk);
        req = 4'b1001;
        n = 0;
        while (n_start < s0 + 2 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        req = 4'b1000;
        src_q.delete();
        chk("abort_two_bytes", 32'(n_start - s0), 32'd2);
        n = 0;
        @(negedge clk);
        while (grant !== 4'b1000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_regrant", 32'(grant), 32'h8);
        chk("abort_gap", 32'(cyc - fall_cyc), 32'd3);
        chk("abort_no_err", 32'(err_seen), 32'd0);
        req = '0;
        wait_idle("abort_settle", 20);

        // Transmitter never raises busy
        ack_en = 1'b0;
        src_idx = 2;
        push_byte(2, 8'hC3, 1'b0, 1'b1);
        push_byte(2, 8'h3C, 1'b1, 1'b1);
        @(negedge clk);
        req = 4'b0100;
        wait_sb_empty("guard_bytes", 100);
        req = '0;
        chk("guard_gap", 32'(last_start - prev_start), 32'd6);
        wait_idle("guard_settle", 30);
        ack_en = 1'b1;

        // Reset while the transmitter is busy
        busy_len = 20;
        src_idx = 1;
        push_byte(1, 8'h5A, 1'b0, 1'b1);
        push_byte(1, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        req = 4'b0010;
        wait_sb_empty("rst_first_byte", 100);
        n = 0;
        @(negedge clk);
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        req = '0;
        src_q.delete();
        mptr = 0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", 32'(arb_idle), 32'd1);
        chk("rst_release_grant", 32'(grant), 32'd0);

        // Contention among requesters 0, 1 and 3
        busy_len = 3;
        for (int p = 0; p < 4; p++) begin
            int w;
            w = pick(4'b1011, mptr);
            e.idx  = 3'(w);
            e.data = 8'(160 + w);
            sb.push_back(e);
`ifdef UART_ARB_RR_EN
            mptr = (w + 1) % int'(N_REQ);
`endif
        end
        auto_mask = 4'b1011;
        @(negedge clk);
        req = 4'b1011;
        wait_sb_empty("cont_order", 300);
        req = '0;
        auto_mask = '0;
        wait_idle("cont_settle", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
